// File: rtl/rv32_pkg.sv
// rv32_pkg
// Shared definitions for the RV32I decode stage: opcode encodings, the
// bubble instruction, immediate format selector, the bundled control word
// and a helper that assembles a sign-extended immediate from an instruction.

package rv32_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;

    // addi x0,x0,0 -- injected whenever the pipeline needs an empty slot
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic illegal;
    } ctrl_t;

    // Scatter/gather of the immediate bits; every format sign-extends from
    // instr[31], branch and jump offsets carry an implicit zero LSB.
    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr,
                                                input imm_fmt_e    fmt);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// regfile
// 32 x 32 architectural register file, two combinational read ports and one
// synchronous write port. A write landing in the same cycle as a read of the
// same register is forwarded straight to the read port, so the decode stage
// never sees a stale value from the instruction retiring in write-back.
//
// Ports:
//   clock, reset        rising-edge clock, async active-high reset (clears all)
//   i_wb_we/rd/data     write-back port; writes to x0 are discarded
//   i_rs1, i_rs2        read addresses
//   o_rs1_data/rs2_data read data (x0 always 0, bypassed from write-back)

module regfile
    import rv32_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data
);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            w_wr_en;

    assign w_wr_en = i_wb_we && (i_wb_rd != 5'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    // x0 is hardwired; otherwise a matching write-back wins over the array
    always_comb begin
        o_rs1_data = r_regs[i_rs1];
        o_rs2_data = r_regs[i_rs2];
        if (i_rs1 == 5'd0) begin
            o_rs1_data = '0;
        end else if (w_wr_en && (i_wb_rd == i_rs1)) begin
            o_rs1_data = i_wb_data;
        end
        if (i_rs2 == 5'd0) begin
            o_rs2_data = '0;
        end else if (w_wr_en && (i_wb_rd == i_rs2)) begin
            o_rs2_data = i_wb_data;
        end
    end

endmodule

// File: rtl/id_stage.sv
// id_stage
// RV32I instruction decode stage. Holds the IF/ID pipeline register, reads
// the register file, generates the immediate and control word, detects
// load-use hazards and registers everything into the ID/EX boundary.
//
// Ports:
//   clock, reset              rising-edge clock, async active-high reset
//   i_if_instruction/pc/valid fetch output
//   i_flush                   taken branch/jump in EX, squash IF/ID and ID/EX
//   i_ex_mem_read, i_ex_rd    load currently in EX and its destination
//   i_wb_we/rd/data           register file write-back port
//   o_stall                   combinational, freezes fetch and IF/ID
//   o_id_*                    registered decode results for execute

module id_stage
    import rv32_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     i_if_instruction,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic            i_if_valid,
    input  logic            i_flush,
    input  logic            i_ex_mem_read,
    input  logic [4:0]      i_ex_rd,
    input  logic            i_wb_we,
    input  logic [4:0]      i_wb_rd,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_stall,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_rs1_data,
    output logic [XLEN-1:0] o_id_rs2_data,
    output logic [XLEN-1:0] o_id_imm,
    output logic [4:0]      o_id_rs1,
    output logic [4:0]      o_id_rs2,
    output logic [4:0]      o_id_rd,
    output logic [2:0]      o_id_funct3,
    output logic            o_id_funct7b5,
    output logic [6:0]      o_id_opcode,
    output logic            o_id_reg_write,
    output logic            o_id_mem_read,
    output logic            o_id_mem_write,
    output logic            o_id_branch,
    output logic            o_id_jump,
    output logic            o_id_alu_src,
    output logic            o_id_illegal
);

    logic [31:0]     r_ifid_instr;
    logic [XLEN-1:0] r_ifid_pc;
    logic            r_ifid_valid;

    logic            r_id_valid;
    logic [XLEN-1:0] r_id_pc;
    logic [XLEN-1:0] r_id_rs1_data;
    logic [XLEN-1:0] r_id_rs2_data;
    logic [XLEN-1:0] r_id_imm;
    logic [4:0]      r_id_rs1;
    logic [4:0]      r_id_rs2;
    logic [4:0]      r_id_rd;
    logic [2:0]      r_id_funct3;
    logic            r_id_funct7b5;
    logic [6:0]      r_id_opcode;
    ctrl_t           r_id_ctrl;

    logic [6:0]      w_opcode;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [XLEN-1:0] w_imm;
    imm_fmt_e        w_imm_fmt;
    ctrl_t           w_ctrl;
    logic            w_uses_rs1;
    logic            w_uses_rs2;
    logic            w_stall;

    assign w_opcode   = r_ifid_instr[6:0];
    assign w_rd       = r_ifid_instr[11:7];
    assign w_funct3   = r_ifid_instr[14:12];
    assign w_rs1      = r_ifid_instr[19:15];
    assign w_rs2      = r_ifid_instr[24:20];
    assign w_funct7b5 = r_ifid_instr[30];

    // IF/ID: flush beats stall, stall freezes the slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= '0;
            r_ifid_valid <= 1'b0;
        end else if (i_flush) begin
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (!w_stall) begin
            r_ifid_instr <= i_if_instruction;
            r_ifid_pc    <= i_if_pc;
            r_ifid_valid <= i_if_valid;
        end
    end

    regfile u_regfile (
        .clock      (clock),
        .reset      (reset),
        .i_wb_we    (i_wb_we),
        .i_wb_rd    (i_wb_rd),
        .i_wb_data  (i_wb_data),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data)
    );

    // Main control and operand usage by opcode. An empty IF/ID slot must not
    // raise any control bit, including illegal.
    always_comb begin
        w_ctrl     = '0;
        w_imm_fmt  = IMM_NONE;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_ctrl.reg_write = 1'b1;
                w_uses_rs2       = 1'b1;
            end
            OP_IMM: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm_fmt        = IMM_I;
            end
            OP_LOAD: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm_fmt        = IMM_I;
            end
            OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm_fmt        = IMM_S;
                w_uses_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                w_ctrl.branch = 1'b1;
                w_imm_fmt     = IMM_B;
                w_uses_rs2    = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_imm_fmt        = IMM_J;
                w_uses_rs1       = 1'b0;
            end
            OP_JALR: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm_fmt        = IMM_I;
            end
            OP_LUI, OP_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                w_imm_fmt        = IMM_U;
                w_uses_rs1       = 1'b0;
            end
            default: begin
                w_ctrl.illegal = 1'b1;
            end
        endcase
        if (!r_ifid_valid) begin
            w_ctrl = '0;
        end
    end

    assign w_imm = gen_imm(r_ifid_instr, w_imm_fmt);

    // Load-use: the load in EX produces its value too late for this slot.
    // A flush discards the dependent instruction anyway, so never stall then.
    assign w_stall = r_ifid_valid && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                     ((w_uses_rs1 && (w_rs1 == i_ex_rd)) ||
                      (w_uses_rs2 && (w_rs2 == i_ex_rd))) &&
                     !i_flush;

    assign o_stall = w_stall;

    // ID/EX: flush or stall inserts an all-zero bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset || i_flush || w_stall) begin
            if (reset) begin
                r_id_valid <= 1'b0;
            end else begin
                r_id_valid <= 1'b0;
            end
            r_id_pc       <= '0;
            r_id_rs1_data <= '0;
            r_id_rs2_data <= '0;
            r_id_imm      <= '0;
            r_id_rs1      <= '0;
            r_id_rs2      <= '0;
            r_id_rd       <= '0;
            r_id_funct3   <= '0;
            r_id_funct7b5 <= 1'b0;
            r_id_opcode   <= '0;
            r_id_ctrl     <= '0;
        end else begin
            r_id_valid    <= r_ifid_valid;
            r_id_pc       <= r_ifid_pc;
            r_id_rs1_data <= w_rs1_data;
            r_id_rs2_data <= w_rs2_data;
            r_id_imm      <= w_imm;
            r_id_rs1      <= w_rs1;
            r_id_rs2      <= w_rs2;
            r_id_rd       <= w_rd;
            r_id_funct3   <= w_funct3;
            r_id_funct7b5 <= w_funct7b5;
            r_id_opcode   <= w_opcode;
            r_id_ctrl     <= w_ctrl;
        end
    end

    assign o_id_valid     = r_id_valid;
    assign o_id_pc        = r_id_pc;
    assign o_id_rs1_data  = r_id_rs1_data;
    assign o_id_rs2_data  = r_id_rs2_data;
    assign o_id_imm       = r_id_imm;
    assign o_id_rs1       = r_id_rs1;
    assign o_id_rs2       = r_id_rs2;
    assign o_id_rd        = r_id_rd;
    assign o_id_funct3    = r_id_funct3;
    assign o_id_funct7b5  = r_id_funct7b5;
    assign o_id_opcode    = r_id_opcode;
    assign o_id_reg_write = r_id_ctrl.reg_write;
    assign o_id_mem_read  = r_id_ctrl.mem_read;
    assign o_id_mem_write = r_id_ctrl.mem_write;
    assign o_id_branch    = r_id_ctrl.branch;
    assign o_id_jump      = r_id_ctrl.jump;
    assign o_id_alu_src   = r_id_ctrl.alu_src;
    assign o_id_illegal   = r_id_ctrl.illegal;

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage directly downstream of ifetch in the 5-stage RV32I pipeline. It has four parts:
- IF/ID pipeline register capturing instruction/PC.
- 32x32 register file with write-back port.
- Immediate generation and main control decode.
- Load-use hazard detection that stalls ifetch.

All outputs are registered into the ID/EX boundary for the execute stage.

Parameters:
XLEN, 32, datapath/PC width
NUM_REGS, 32, architectural registers (index width = 5)
NOP_INSTR, 32'h0000_0013, instruction injected on bubble/flush (addi x0,x0,0)

Ports:
clock  in  1  rising-edge clock
reset  in  1  reset, asynchronous, active-high
if_instruction  in  32  fetched instruction from ifetch
if_pc  in  32  PC of if_instruction
if_valid  in  1  fetch output valid this cycle
flush  in  1  branch/jump taken in EX; squash IF/ID and ID/EX contents
ex_mem_read  in  1  instruction currently in EX is a load
ex_rd  in  5  destination of instruction in EX
wb_we  in  1  write-back enable
wb_rd  in  5  write-back destination
wb_data  in  32  write-back data
stall  out  1  combinational; holds ifetch PC and IF/ID register
id_valid  out  1  ID/EX entry valid
id_pc  out  32  PC of decoded instruction
id_rs1_data, id_rs2_data  out  32 each  operand values
id_imm  out  32  sign-extended immediate
id_rs1, id_rs2, id_rd  out  5 each  register indices
id_funct3  out  3  funct3 field
id_funct7b5  out  1  instr[30]
id_opcode  out  7  opcode field
id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump, id_alu_src  out  1 each  control
id_illegal  out  1  unrecognised opcode

Behaviour:
Reset (asynchronous, while reset=1):
- IF/ID holds NOP_INSTR, valid=0, PC=0.
- All id_* outputs are 0.
- All 32 registers are 0.
- stall=0.

IF/ID register, each rising edge:
- flush=1: load NOP_INSTR, valid=0. Flush has priority over stall.
- else stall=1: hold current contents.
- else: load {if_instruction, if_pc, if_valid}.

ID/EX outputs, each rising edge:
- flush=1 or stall=1: bubble. id_valid=0, all control outputs 0, data fields 0.
- else: register the decode of the IF/ID contents.
- An IF/ID entry with valid=0 also produces control outputs 0.

Latency: an instruction presented on if_* at edge N appears on id_* after edge N+1.

Hazard detection:
- stall = ifid_valid & ex_mem_read & (ex_rd!=0) & ((uses_rs1 & rs1==ex_rd) | (uses_rs2 & rs2==ex_rd)).
- uses_rs1 is false for LUI, AUIPC, JAL.
- uses_rs2 is true only for R-type, store, branch.
- stall is forced to 0 when flush=1.

Register file:
- Synchronous write on rising edge when wb_we=1 and wb_rd!=0.
- x0 always reads 0.
- Read is combinational with write-through bypass: if wb_we & wb_rd!=0 & wb_rd==rsN, then rsN_data=wb_data in the same cycle.

Control decode (by opcode):
- 0110011 R: reg_write.
- 0010011 I-ALU: reg_write, alu_src.
- 0000011 load: reg_write, mem_read, alu_src.
- 0100011 store: mem_write, alu_src.
- 1100011 branch: branch.
- 1101111 JAL: reg_write, jump.
- 1100111 JALR: reg_write, jump, alu_src.
- 0110111 LUI: reg_write, alu_src.
- 0010111 AUIPC: reg_write, alu_src.
- Any other opcode: all control 0, id_illegal=1 (only when the entry is valid).

Immediates (all sign-extended from instr[31]):
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R-type: 0.

Boundary conditions:
- Simultaneous stall condition and flush: flush wins and no stall occurs.
- Write-back to x0: ignored.
- Reset asserted mid-stall: stall drops immediately (asynchronous).
- Back-to-back load-use produces exactly one bubble per dependency.

Decomposition:
- Package rv32_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - NOP_INSTR;
  - imm_fmt_e enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE};
  - ctrl_t struct bundling the six control bits and the illegal flag.
- One sub-module, regfile (2R/1W with bypass), instantiated inside id_stage.
- Immediate generation and control decode are combinational logic inside id_stage.

Test Plan:
1. Reset, then present 32'h00500093 (addi x1,x0,5), PC=0x0 → two edges later: id_rd=1, id_imm=5, reg_write=1, alu_src=1, id_valid=1.
2. wb_we=1, wb_rd=3, wb_data=0xDEADBEEF in the same cycle as IF/ID holds add x4,x3,x3 → id_rs1_data = id_rs2_data = 0xDEADBEEF (bypass). A write with wb_rd=0 leaves x0 reading 0.
3. ex_mem_read=1, ex_rd=5, IF/ID holds add x6,x5,x0 → stall=1 for one cycle, IF/ID holds, next id_valid=0. The following cycle, with ex_mem_read=0, the add issues.
4. Same load-use as scenario 3 plus flush=1 → stall=0, IF/ID=NOP_INSTR, id_valid=0.
5. Immediate checks:
   - beq with offset -8 (32'hFE000CE3) → id_imm=0xFFFFFFF8, branch=1.
   - lui 32'h12345037 → id_imm=0x12345000.
   - jal 32'h008000EF → id_imm=8, jump=1.
6. Opcode 0x7F with valid=1 → id_illegal=1, all control 0. Assert reset mid-stream → every id_* output is 0 before the next edge.
